dpll_lock_controller: RTL
=========================

# dpll_lock_controller

Sequencer and gain scheduler for the DPLL loop. It holds the loop in reset after enable and selects the loop-filter modulus exponent: wide bandwidth for acquisition, narrow for tracking. It measures loop-filter correction activity (carry plus borrow pulses) per window of reference edges, declares lock, and detects loss of lock. It sits beside the phase detector, loop filter and DCO in the baseClockInput domain and drives their configuration and reset inputs.

## Interface
- WIN_EDGES, 64: reference edges per measurement window
- LOCK_THR, 4: max corrections in a window for the window to count as quiet
- UNLOCK_THR, 16: corrections in a window above which lock is lost
- LOCK_WINDOWS, 4: consecutive quiet windows required to advance state
- K_FAST, 3: kExp value used in ACQUIRE
- K_SLOW, 8: kExp value used in TRACK and LOCKED
- RST_CYCLES, 16: loop-reset hold length in clocks
- CNT_W, 8: width of the correction counter

Ports:
- baseClockInput  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high
- enable  in  1  run request, level
- refEdge  in  1  one-cycle pulse per reference period (already synchronized)
- dlfCarry  in  1  one-cycle loop-filter carry pulse
- dlfBorrow  in  1  one-cycle loop-filter borrow pulse
- kExp  out  4  loop-filter modulus exponent
- loopReset  out  1  active-high reset to the phase detector, loop filter and DCO
- dcoEnable  out  1  DCO run enable
- locked  out  1  high exactly while state is LOCKED
- state  out  3  IDLE=0, RESET_LOOP=1, ACQUIRE=2, TRACK=3, LOCKED=4
- lossCount  out  8  number of LOCKED->ACQUIRE transitions, saturates at 255

## Operation
- Reset values:
  - state=IDLE, kExp=K_FAST, loopReset=1, dcoEnable=0, locked=0, lossCount=0
  - all internal counters 0
- IDLE:
  - loopReset=1, dcoEnable=0
  - enable=1 -> RESET_LOOP
- RESET_LOOP:
  - loopReset=1, dcoEnable=1, kExp=K_FAST
  - after exactly RST_CYCLES clocks -> ACQUIRE
- ACQUIRE:
  - loopReset=0, kExp=K_FAST
  - LOCK_WINDOWS consecutive quiet windows -> TRACK
- TRACK:
  - kExp=K_SLOW
  - LOCK_WINDOWS consecutive quiet windows -> LOCKED
  - a window with count > UNLOCK_THR -> ACQUIRE
- LOCKED:
  - kExp=K_SLOW, locked=1
  - a window with count > UNLOCK_THR -> ACQUIRE, and lossCount increments
- enable=0 in any state -> IDLE on the next clock. This has priority over all other transitions.
- Measurement window:
  - Counts refEdge pulses and corrections.
  - Carry and borrow in the same cycle add 2.
  - The correction count saturates at 2^CNT_W-1.
  - The window closes on the WIN_EDGES-th refEdge. A correction in the closing cycle belongs to the closing window.
  - The next window starts at zero on the following cycle.
- A window that is neither quiet nor above UNLOCK_THR resets the quiet-window run and does not change state.
- Every state transition clears the window counters and the quiet-window run, so evaluation restarts aligned to the transition.
- Windows are evaluated only in ACQUIRE, TRACK and LOCKED.

## Timing
- All outputs are registered.
- State changes on the clock after the closing refEdge. kExp, loopReset and locked reflect the new state in that same registered update, which is 1 cycle of latency.
- RESET_LOOP lasts exactly RST_CYCLES cycles with state==1.
- Asynchronous reset mid-operation forces the reset values immediately. Deassertion resumes from IDLE.
- refEdge with no corrections over a full window produces count 0, which is quiet.

## Structure
- Package dpll_ctrl_pkg holds:
  - the state encoding constants
  - default parameter constants
- Sub-module dpll_activity_window:
  - inputs: refEdge, dlfCarry, dlfBorrow, clear
  - outputs: windowDone pulse and the saturated count
- The top level holds the FSM, the quiet-window run counter, the reset-hold counter and lossCount.

## Test plan
- Reset then enable=1 -> state 0->1 for 16 cycles -> 2, with loopReset falling on entry to state 2 and kExp=3.
- No corrections, refEdge every 8 clocks -> TRACK after 4×64 edges (kExp=8), then LOCKED after 4 more windows, with locked=1.
- In LOCKED, inject 17 carries in one window -> ACQUIRE one cycle after window close, lossCount=1, kExp=3.
- Carry and borrow asserted together 3 times in one window gives count 6. That window is not quiet, so the quiet-window run resets and the state holds.
- enable=0 mid-TRACK -> IDLE next clock, loopReset=1, dcoEnable=0. Re-enable repeats the 16-cycle RESET_LOOP.
- Force 300 lock losses -> lossCount saturates at 255. Assert reset mid-window -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/dpll_ctrl_pkg.sv
// dpll_ctrl_pkg: state encoding and default tuning constants
// shared by the DPLL lock controller and its activity window.
package dpll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_LOOP = 3'd1,
        ST_ACQUIRE    = 3'd2,
        ST_TRACK      = 3'd3,
        ST_LOCKED     = 3'd4
    } dpll_state_t;

    localparam int         DEF_WIN_EDGES    = 64;
    localparam int         DEF_LOCK_THR     = 4;
    localparam int         DEF_UNLOCK_THR   = 16;
    localparam int         DEF_LOCK_WINDOWS = 4;
    localparam logic [3:0] DEF_K_FAST       = 4'd3;
    localparam logic [3:0] DEF_K_SLOW       = 4'd8;
    localparam int         DEF_RST_CYCLES   = 16;
    localparam int         DEF_CNT_W        = 8;

endpackage

// File: rtl/dpll_activity_window.sv
// dpll_activity_window: counts loop-filter corrections over a window of
// reference edges; the closing cycle's corrections belong to that window.
module dpll_activity_window
    import dpll_ctrl_pkg::*;
#(
    parameter int WIN_EDGES = DEF_WIN_EDGES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_refEdge,
    input  logic             i_dlfCarry,
    input  logic             i_dlfBorrow,
    input  logic             i_clear,
    output logic             o_windowDone,
    output logic [CNT_W-1:0] o_count
);

    localparam int EDGE_W = $clog2(WIN_EDGES + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(WIN_EDGES - 1);

    logic [EDGE_W-1:0] r_edgeCnt;
    logic [CNT_W-1:0]  r_corrCnt;
    logic [1:0]        w_inc;
    logic [CNT_W:0]    w_sum;
    logic [CNT_W-1:0]  w_count;
    logic              w_done;

    assign w_inc   = {1'b0, i_dlfCarry} + {1'b0, i_dlfBorrow};
    assign w_sum   = {1'b0, r_corrCnt} + {{(CNT_W - 1){1'b0}}, w_inc};
    assign w_count = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    assign w_done  = i_refEdge && (r_edgeCnt == LAST_EDGE);

    assign o_windowDone = w_done;
    assign o_count      = w_count;

    // Accumulate edges and saturating corrections; restart on close or clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_edgeCnt <= '0;
            r_corrCnt <= '0;
        end else if (i_clear || w_done) begin
            r_edgeCnt <= '0;
            r_corrCnt <= '0;
        end else begin
            r_edgeCnt <= r_edgeCnt + EDGE_W'(i_refEdge);
            r_corrCnt <= w_count;
        end
    end

endmodule

// File: rtl/dpll_lock_controller.sv
// dpll_lock_controller: sequences DPLL loop reset, schedules loop-filter
// gain and tracks lock / loss of lock from correction activity.
module dpll_lock_controller
    import dpll_ctrl_pkg::*;
#(
    parameter int         WIN_EDGES    = DEF_WIN_EDGES,
    parameter int         LOCK_THR     = DEF_LOCK_THR,
    parameter int         UNLOCK_THR   = DEF_UNLOCK_THR,
    parameter int         LOCK_WINDOWS = DEF_LOCK_WINDOWS,
    parameter logic [3:0] K_FAST       = DEF_K_FAST,
    parameter logic [3:0] K_SLOW       = DEF_K_SLOW,
    parameter int         RST_CYCLES   = DEF_RST_CYCLES,
    parameter int         CNT_W        = DEF_CNT_W
) (
    input  logic       baseClockInput,
    input  logic       reset,
    input  logic       enable,
    input  logic       refEdge,
    input  logic       dlfCarry,
    input  logic       dlfBorrow,
    output logic [3:0] kExp,
    output logic       loopReset,
    output logic       dcoEnable,
    output logic       locked,
    output logic [2:0] state,
    output logic [7:0] lossCount
);

    localparam int RUN_W  = $clog2(LOCK_WINDOWS + 1);
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam logic [RUN_W-1:0]  RUN_LAST   = RUN_W'(LOCK_WINDOWS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  QUIET_MAX  = CNT_W'(LOCK_THR);
    localparam logic [CNT_W-1:0]  UNLOCK_LIM = CNT_W'(UNLOCK_THR);

    dpll_state_t       r_state;
    dpll_state_t       w_next;
    logic [RUN_W-1:0]  r_quietRun;
    logic [RUN_W-1:0]  w_runNext;
    logic [HOLD_W-1:0] r_holdCnt;
    logic [3:0]        r_kExp;
    logic              r_loopReset;
    logic              r_dcoEnable;
    logic              r_locked;
    logic [7:0]        r_lossCount;

    logic              w_evaluating;
    logic              w_clear;
    logic              w_windowDone;
    logic [CNT_W-1:0]  w_count;
    logic              w_quiet;
    logic              w_loud;
    logic              w_runDone;
    logic              w_lost;

    assign w_evaluating = (r_state == ST_ACQUIRE) ||
                          (r_state == ST_TRACK) ||
                          (r_state == ST_LOCKED);
    // Outside the evaluating states (or on disable) the window is held at
    // zero, so entry into ACQUIRE starts a fresh, aligned window.
    assign w_clear   = !enable || !w_evaluating;
    assign w_quiet   = (w_count <= QUIET_MAX);
    assign w_loud    = (w_count > UNLOCK_LIM);
    assign w_runDone = w_quiet && (r_quietRun == RUN_LAST);
    assign w_lost    = (r_state == ST_LOCKED) && (w_next == ST_ACQUIRE);

    dpll_activity_window #(
        .WIN_EDGES (WIN_EDGES),
        .CNT_W     (CNT_W)
    ) u_window (
        .i_clk        (baseClockInput),
        .i_rst        (reset),
        .i_refEdge    (refEdge),
        .i_dlfCarry   (dlfCarry),
        .i_dlfBorrow  (dlfBorrow),
        .i_clear      (w_clear),
        .o_windowDone (w_windowDone),
        .o_count      (w_count)
    );

    // Next-state selection; disable overrides every other transition.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (enable) w_next = ST_RESET_LOOP;
            end
            ST_RESET_LOOP: begin
                if (r_holdCnt == HOLD_LAST) w_next = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (w_windowDone && w_runDone) w_next = ST_TRACK;
            end
            ST_TRACK: begin
                if (w_windowDone && w_runDone)   w_next = ST_LOCKED;
                else if (w_windowDone && w_loud) w_next = ST_ACQUIRE;
            end
            ST_LOCKED: begin
                if (w_windowDone && w_loud) w_next = ST_ACQUIRE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (!enable) w_next = ST_IDLE;
    end

    // Quiet-window run: restarts on any transition or non-quiet window.
    always_comb begin
        w_runNext = r_quietRun;
        if (w_next != r_state) begin
            w_runNext = '0;
        end else if (w_windowDone && w_evaluating) begin
            w_runNext = (w_quiet && !w_runDone) ? r_quietRun + 1'b1 : '0;
        end
    end

    // State, hold counter, loss counter and outputs decoded from next state.
    always_ff @(posedge baseClockInput or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_quietRun  <= '0;
            r_holdCnt   <= '0;
            r_kExp      <= K_FAST;
            r_loopReset <= 1'b1;
            r_dcoEnable <= 1'b0;
            r_locked    <= 1'b0;
            r_lossCount <= '0;
        end else begin
            r_state    <= w_next;
            r_quietRun <= w_runNext;
            r_holdCnt  <= ((r_state == ST_RESET_LOOP) &&
                           (w_next == ST_RESET_LOOP)) ? r_holdCnt + 1'b1 : '0;
            r_kExp      <= ((w_next == ST_TRACK) || (w_next == ST_LOCKED)) ?
                           K_SLOW : K_FAST;
            r_loopReset <= (w_next == ST_IDLE) || (w_next == ST_RESET_LOOP);
            r_dcoEnable <= (w_next != ST_IDLE);
            r_locked    <= (w_next == ST_LOCKED);
            if (w_lost && (r_lossCount != 8'hFF)) begin
                r_lossCount <= r_lossCount + 8'd1;
            end
        end
    end

    assign state     = r_state;
    assign kExp      = r_kExp;
    assign loopReset = r_loopReset;
    assign dcoEnable = r_dcoEnable;
    assign locked    = r_locked;
    assign lossCount = r_lossCount;

endmodule
